// File: rtl/conv3x3_kernel_sel.sv
// Streaming 3x3 convolution stage with a frame-latched kernel select.
// Four register stages (taps, row sums, total/round, abs/clamp) with a matching sync delay.
module conv3x3_kernel_sel #(
    parameter int COLORDEPTH  = 8,
    parameter int CHANNELS    = 1,
    parameter int ZERO_BORDER = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHANNELS*3*COLORDEPTH-1:0] vect_i,
    input  logic [2:0]                       mode_i,
    input  logic                             dv_i,
    input  logic                             hs_i,
    input  logic                             vs_i,
    output logic [CHANNELS*COLORDEPTH-1:0]   conv_o,
    output logic                             dv_o,
    output logic                             hs_o,
    output logic                             vs_o,
    output logic                             line_end_o,
    output logic [2:0]                       mode_o
);

    localparam int ACC_W = COLORDEPTH + 5;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [COLORDEPTH-1:0]   pix_t;

    localparam logic [2:0] MODE_GAUSS   = 3'd1;
    localparam logic [2:0] MODE_SOBEL_X = 3'd2;
    localparam logic [2:0] MODE_SOBEL_Y = 3'd3;
    localparam logic [2:0] MODE_SHARPEN = 3'd4;
    localparam acc_t PIX_MAX_C   = $signed({5'b00000, {COLORDEPTH{1'b1}}});
    localparam acc_t GAUSS_RND_C = $signed({{(ACC_W-4){1'b0}}, 4'd8});
    localparam logic BLANK_EN_C  = (ZERO_BORDER != 32'sd0);

    function automatic acc_t ext(input pix_t p);
        return $signed({5'b00000, p});
    endfunction

    function automatic acc_t tri_sum(input pix_t a, input pix_t b, input pix_t c);
        return ext(a) + (ext(b) <<< 1'b1) + ext(c);
    endfunction

    pix_t tap_r [CHANNELS][3][3];
    acc_t row_s [CHANNELS][3];
    acc_t row_r [CHANNELS][3];
    acc_t tot_s [CHANNELS];
    acc_t sum_s [CHANNELS];
    acc_t sum_r [CHANNELS];
    acc_t mag_s [CHANNELS];
    logic [CHANNELS*COLORDEPTH-1:0] conv_s, conv_r;
    logic [2:0] mode_r, mode_eff_s, mode_p1_r, mode_p2_r, mode_p3_r;
    logic       blank_s, blank_p1_r, blank_p2_r, blank_p3_r;
    logic [1:0] cnt_r, cnt_next_s, pix_idx_s;
    logic       vs_rise_s, dv_rise_s;
    logic [3:0] dv_pipe_r, hs_pipe_r, vs_pipe_r;
    logic       line_end_r;

    // Edge detection, frame-edge mode pick and per-line border position.
    always_comb begin
        vs_rise_s = vs_i & ~vs_pipe_r[0];
        dv_rise_s = dv_i & ~dv_pipe_r[0];
        if (vs_rise_s) mode_eff_s = mode_i;
        else           mode_eff_s = mode_r;
        if (dv_rise_s) pix_idx_s = 2'd0;
        else           pix_idx_s = cnt_r;
        if (!dv_i)                  cnt_next_s = cnt_r;
        else if (pix_idx_s == 2'd2) cnt_next_s = 2'd2;
        else                        cnt_next_s = pix_idx_s + 2'd1;
        blank_s = BLANK_EN_C && (pix_idx_s != 2'd2);
    end

    // Control state: mode latch, border counter, sync delay lines and sideband pipes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r     <= MODE_GAUSS;
            mode_p1_r  <= 3'd0;
            mode_p2_r  <= 3'd0;
            mode_p3_r  <= 3'd0;
            blank_p1_r <= 1'b0;
            blank_p2_r <= 1'b0;
            blank_p3_r <= 1'b0;
            cnt_r      <= 2'd0;
            dv_pipe_r  <= 4'd0;
            hs_pipe_r  <= 4'd0;
            vs_pipe_r  <= 4'd0;
            line_end_r <= 1'b0;
        end else begin
            mode_r     <= mode_eff_s;
            mode_p1_r  <= mode_eff_s;
            mode_p2_r  <= mode_p1_r;
            mode_p3_r  <= mode_p2_r;
            blank_p1_r <= blank_s;
            blank_p2_r <= blank_p1_r;
            blank_p3_r <= blank_p2_r;
            cnt_r      <= cnt_next_s;
            dv_pipe_r  <= {dv_pipe_r[2:0], dv_i};
            hs_pipe_r  <= {hs_pipe_r[2:0], hs_i};
            vs_pipe_r  <= {vs_pipe_r[2:0], vs_i};
            line_end_r <= dv_pipe_r[3] & ~dv_pipe_r[2];
        end
    end

    // Tap window: unconditional one-column shift, newest column into c0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        tap_r[ch][r][c] <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int r = 0; r < 3; r++) begin
                    tap_r[ch][r][2] <= tap_r[ch][r][1];
                    tap_r[ch][r][1] <= tap_r[ch][r][0];
                    tap_r[ch][r][0] <= vect_i[(ch*3+r)*COLORDEPTH +: COLORDEPTH];
                end
            end
        end
    end

    // Per-row weighted sums for the kernel that travelled with this column.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int r = 0; r < 3; r++) row_s[ch][r] = '0;
            case (mode_p1_r)
                MODE_GAUSS: begin
                    row_s[ch][0] = tri_sum(tap_r[ch][0][0], tap_r[ch][0][1], tap_r[ch][0][2]);
                    row_s[ch][1] = tri_sum(tap_r[ch][1][0], tap_r[ch][1][1], tap_r[ch][1][2]) <<< 1'b1;
                    row_s[ch][2] = tri_sum(tap_r[ch][2][0], tap_r[ch][2][1], tap_r[ch][2][2]);
                end
                MODE_SOBEL_X: begin
                    row_s[ch][0] = ext(tap_r[ch][0][0]) - ext(tap_r[ch][0][2]);
                    row_s[ch][1] = (ext(tap_r[ch][1][0]) - ext(tap_r[ch][1][2])) <<< 1'b1;
                    row_s[ch][2] = ext(tap_r[ch][2][0]) - ext(tap_r[ch][2][2]);
                end
                MODE_SOBEL_Y: begin
                    row_s[ch][0] = tri_sum(tap_r[ch][0][0], tap_r[ch][0][1], tap_r[ch][0][2]);
                    row_s[ch][2] = -tri_sum(tap_r[ch][2][0], tap_r[ch][2][1], tap_r[ch][2][2]);
                end
                MODE_SHARPEN: begin
                    row_s[ch][0] = -ext(tap_r[ch][0][1]);
                    row_s[ch][1] = (ext(tap_r[ch][1][1]) <<< 2'd2) + ext(tap_r[ch][1][1])
                                   - ext(tap_r[ch][1][0]) - ext(tap_r[ch][1][2]);
                    row_s[ch][2] = -ext(tap_r[ch][2][1]);
                end
                default: begin
                    row_s[ch][1] = ext(tap_r[ch][1][1]);
                end
            endcase
        end
    end

    // Window total, with the Gaussian normalisation rounded to nearest.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            tot_s[ch] = row_r[ch][0] + row_r[ch][1] + row_r[ch][2];
            if (mode_p2_r == MODE_GAUSS) sum_s[ch] = (tot_s[ch] + GAUSS_RND_C) >>> 3'd4;
            else                         sum_s[ch] = tot_s[ch];
        end
    end

    // Magnitude for gradient kernels, clamp to pixel range, blank incomplete windows.
    always_comb begin
        conv_s = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (((mode_p3_r == MODE_SOBEL_X) || (mode_p3_r == MODE_SOBEL_Y)) && sum_r[ch][ACC_W-1])
                mag_s[ch] = -sum_r[ch];
            else
                mag_s[ch] = sum_r[ch];
            if (blank_p3_r)                conv_s[ch*COLORDEPTH +: COLORDEPTH] = '0;
            else if (mag_s[ch][ACC_W-1])   conv_s[ch*COLORDEPTH +: COLORDEPTH] = '0;
            else if (mag_s[ch] > PIX_MAX_C) conv_s[ch*COLORDEPTH +: COLORDEPTH] = '1;
            else                           conv_s[ch*COLORDEPTH +: COLORDEPTH] = mag_s[ch][COLORDEPTH-1:0];
        end
    end

    // Datapath stages S2..S4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int r = 0; r < 3; r++) row_r[ch][r] <= '0;
                sum_r[ch] <= '0;
            end
            conv_r <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int r = 0; r < 3; r++) row_r[ch][r] <= row_s[ch][r];
                sum_r[ch] <= sum_s[ch];
            end
            conv_r <= conv_s;
        end
    end

    assign conv_o     = conv_r;
    assign dv_o       = dv_pipe_r[3];
    assign hs_o       = hs_pipe_r[3];
    assign vs_o       = vs_pipe_r[3];
    assign line_end_o = line_end_r;
    assign mode_o     = mode_r;

endmodule

// File: tb/tb_conv3x3_kernel_sel.sv
// Directed bench for conv3x3_kernel_sel (3 channels, 8-bit, border blanking on).
// A window model predicts each output; predictions are queued and compared 4 clocks later.
module tb_conv3x3_kernel_sel;

    localparam int CD = 8;
    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [71:0]   vect_i;
    logic [2:0]    mode_i;
    logic          dv_i, hs_i, vs_i;
    logic [23:0]   conv_o;
    logic          dv_o, hs_o, vs_o, line_end_o;
    logic [2:0]    mode_o;

    conv3x3_kernel_sel #(.COLORDEPTH(CD), .CHANNELS(CH), .ZERO_BORDER(1)) dut (
        .clk(clk), .rst_n(rst_n), .vect_i(vect_i), .mode_i(mode_i),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .conv_o(conv_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .line_end_o(line_end_o), .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] conv;
        logic        dv;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   win [CH][3][3];
    int   mlat, cnt;
    logic vs_prev, dv_prev, last_dv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win[ch][r][c] = 0;
        mlat = 1; cnt = 0; vs_prev = 1'b0; dv_prev = 1'b0; last_dv = 1'b0;
        sb_q.delete();
    endtask

    function automatic logic [71:0] col3(input int r0, input int r1, input int r2);
        logic [71:0] v;
        v = '0;
        for (int ch = 0; ch < CH; ch++) begin
            v[(ch*3+0)*8 +: 8] = r0[7:0];
            v[(ch*3+1)*8 +: 8] = r1[7:0];
            v[(ch*3+2)*8 +: 8] = r2[7:0];
        end
        return v;
    endfunction

    function automatic logic [71:0] colch(input int a, input int b, input int c);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            v[(0*3+r)*8 +: 8] = a[7:0];
            v[(1*3+r)*8 +: 8] = b[7:0];
            v[(2*3+r)*8 +: 8] = c[7:0];
        end
        return v;
    endfunction

    function automatic logic [71:0] rnd_col();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // Reference kernel: weight matrix indexed [row][col], col 0 = newest column.
    function automatic logic [7:0] model_px(input int ch, input int m);
        int w [3][3];
        int s;
        case (m)
            1:       w = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
            2:       w = '{'{1, 0, -1}, '{2, 0, -2}, '{1, 0, -1}};
            3:       w = '{'{1, 2, 1}, '{0, 0, 0}, '{-1, -2, -1}};
            4:       w = '{'{0, -1, 0}, '{-1, 5, -1}, '{0, -1, 0}};
            default: w = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
        endcase
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) s += w[r][c] * win[ch][r][c];
        if (m == 1) s = (s + 8) >>> 4;
        if ((m == 2 || m == 3) && s < 0) s = -s;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    task automatic step(input logic [71:0] col, input int m, input logic dv, input logic hs, input logic vs);
        exp_t e;
        int   idx;
        @(negedge clk);
        vect_i = col; mode_i = m[2:0]; dv_i = dv; hs_i = hs; vs_i = vs;
        @(posedge clk);
        if (vs && !vs_prev) mlat = m;
        for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < 3; r++) begin
                win[ch][r][2] = win[ch][r][1];
                win[ch][r][1] = win[ch][r][0];
                win[ch][r][0] = int'(col[(ch*3+r)*8 +: 8]);
            end
        end
        idx = (dv && !dv_prev) ? 0 : cnt;
        if (dv) cnt = (idx >= 2) ? 2 : idx + 1;
        for (int ch = 0; ch < CH; ch++)
            e.conv[ch*8 +: 8] = (idx < 2) ? 8'd0 : model_px(ch, mlat);
        e.dv = dv; e.hs = hs; e.vs = vs;
        sb_q.push_back(e);
        vs_prev = vs; dv_prev = dv;
        #1;
        check("mode_o", 32'(mode_o), 32'(mlat[2:0]));
        if (sb_q.size() > 3) begin
            e = sb_q.pop_front();
            check("dv_o", 32'(dv_o), 32'(e.dv));
            check("hs_o", 32'(hs_o), 32'(e.hs));
            check("vs_o", 32'(vs_o), 32'(e.vs));
            check("line_end_o", 32'(line_end_o), 32'(last_dv & ~e.dv));
            if (e.dv) check("conv_o", 32'(conv_o), 32'(e.conv));
            last_dv = e.dv;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_conv"}, 32'(conv_o), 32'd0);
        check({tag, "_dv"}, 32'(dv_o), 32'd0);
        check({tag, "_hs"}, 32'(hs_o), 32'd0);
        check({tag, "_vs"}, 32'(vs_o), 32'd0);
        check({tag, "_le"}, 32'(line_end_o), 32'd0);
        check({tag, "_mode"}, 32'(mode_o), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; vect_i = '0; mode_i = 3'd1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #2; rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(col3(0, 0, 0), 1, 1'b0, 1'b0, 1'b0);

        // Gaussian, flat field of 100.
        for (int i = 0; i < 10; i++) step(col3(100, 100, 100), 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(col3(0, 0, 0), 1, 1'b0, 1'b1, 1'b0);

        // Independent channels 10/20/30.
        for (int i = 0; i < 6; i++) step(colch(10, 20, 30), 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(col3(0, 0, 0), 1, 1'b0, 1'b0, 1'b0);

        // Mid-frame request for bypass is ignored until the next vsync rise.
        for (int i = 0; i < 6; i++) step(rnd_col(), 0, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 0, 1'b0, 1'b0, 1'b1);
        step(col3(0, 0, 0), 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(rnd_col(), 0, 1'b1, 1'b0, 1'b0);
        step(rnd_col(), 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(rnd_col(), 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(col3(0, 0, 0), 0, 1'b0, 1'b0, 1'b0);

        // Sobel-X selected on the same cycle as the first pixel; 8-pixel line.
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b1);
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b0);
        step(col3(200, 200, 200), 2, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b0);
        step(col3(50, 50, 50), 2, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(col3(0, 0, 0), 2, 1'b0, 1'b0, 1'b0);

        // Sharpen: saturate high, clamp negative, in-range.
        step(col3(0, 0, 0), 4, 1'b0, 1'b0, 1'b1);
        step(col3(0, 0, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 100, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 0, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 100, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(100, 0, 100), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 100, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 50, 0), 4, 1'b1, 1'b0, 1'b0);
        step(col3(50, 60, 50), 4, 1'b1, 1'b0, 1'b0);
        step(col3(0, 50, 0), 4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(col3(0, 0, 0), 4, 1'b0, 1'b0, 1'b0);

        // Sobel-Y, reserved codes and bypass on random data.
        for (int k = 0; k < 4; k++) begin
            int m;
            m = (k == 0) ? 3 : (k == 1) ? 5 : (k == 2) ? 7 : 0;
            step(col3(0, 0, 0), m, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 5; i++) step(rnd_col(), m, 1'b1, 1'b0, 1'b0);
            step(col3(0, 0, 0), m, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < 6; i++) step(rnd_col(), 0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        vect_i = '0; mode_i = 3'd1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(col3(70, 80, 90), 1, 1'b1, 1'b0, 1'b0);
            check("refill_dv", 32'(dv_o), 32'd0);
        end
        for (int i = 0; i < 5; i++) step(rnd_col(), 1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(col3(0, 0, 0), 1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
